// File: rtl/seg7_pkg.sv
// seg7_pkg
// Shared definitions for the seven-segment display path (driver and capture side).
//   SEG_GLYPH[16]    : active-low segment patterns {a,b,c,d,e,f,g} (a = MSB) for hex 0..F
//   AN_DIGIT0..3     : active-low one-hot anode patterns selecting a single digit
//   digit_idx_t      : 2-bit digit index
//   an_decode()      : maps an anode pattern to {valid, idx}; valid = exactly one enable low
package seg7_pkg;

    localparam int SEG_W = 7;
    localparam int AN_W  = 4;
    localparam int SMP_W = AN_W + SEG_W;

    localparam logic [SEG_W-1:0] SEG_GLYPH [16] = '{
        7'b0000001,  // 0
        7'b1001111,  // 1
        7'b0010010,  // 2
        7'b0000110,  // 3
        7'b1001100,  // 4
        7'b0100100,  // 5
        7'b0100000,  // 6
        7'b0001111,  // 7
        7'b0000000,  // 8
        7'b0000100,  // 9
        7'b0001000,  // A
        7'b1100000,  // b
        7'b0110001,  // C
        7'b1000010,  // d
        7'b0110000,  // E
        7'b0111000   // F
    };

    localparam logic [AN_W-1:0] AN_DIGIT0 = 4'b1110;
    localparam logic [AN_W-1:0] AN_DIGIT1 = 4'b1101;
    localparam logic [AN_W-1:0] AN_DIGIT2 = 4'b1011;
    localparam logic [AN_W-1:0] AN_DIGIT3 = 4'b0111;

    typedef logic [1:0] digit_idx_t;

    typedef enum logic {
        FILT_SETTLING = 1'b0,
        FILT_LOCKED   = 1'b1
    } filt_state_t;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

    typedef struct packed {
        logic       valid;
        digit_idx_t idx;
    } an_sel_t;

    // Blanked (1111) and multi-enable patterns are reported as not valid.
    function automatic an_sel_t an_decode(input logic [AN_W-1:0] an);
        an_sel_t sel;
        sel.valid = 1'b1;
        sel.idx   = 2'd0;
        case (an)
            AN_DIGIT0: sel.idx = 2'd0;
            AN_DIGIT1: sel.idx = 2'd1;
            AN_DIGIT2: sel.idx = 2'd2;
            AN_DIGIT3: sel.idx = 2'd3;
            default:   sel.valid = 1'b0;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/seg7_glyph_decode.sv
// seg7_glyph_decode
// Combinational reverse lookup of a seven-segment glyph.
//   pattern : active-low segments {a..g}, a = bit 6
//   nibble  : hex value of the matching glyph (0 when no match)
//   hit     : 1 when pattern is one of the sixteen legal glyphs
module seg7_glyph_decode
    import seg7_pkg::*;
(
    input  logic [SEG_W-1:0] pattern,
    output logic [3:0]       nibble,
    output logic             hit
);

    always_comb begin
        nibble = 4'h0;
        hit    = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (pattern == SEG_GLYPH[i]) begin
                nibble = 4'(i);
                hit    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg7_capture_decoder.sv
// seg7_capture_decoder
// Samples the multiplexed active-low segment/anode lines of a 4-digit display,
// waits for each pattern to settle, decodes it back to a hex nibble and
// assembles {digit3, digit2, digit1, digit0} frames on a valid/ready handshake.
//   clk, rst      : clock, synchronous active-high reset
//   segments_in   : segment lines a..g (index 0 = a), active-low
//   anode_in      : digit enables, active-low, one-hot for a single digit
//   out_value     : frame value, one nibble per digit
//   out_err       : per digit, last accepted pattern was not a legal glyph
//   out_overrun   : some digit was captured more than once within the frame
//   out_valid     : frame available
//   out_ready     : consumer accepts the frame
module seg7_capture_decoder
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [0:SEG_W-1]  segments_in,
    input  logic [AN_W-1:0]   anode_in,
    output logic [15:0]       out_value,
    output logic [3:0]        out_err,
    output logic              out_overrun,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

    // Synchronizer
    logic [SMP_W-1:0] sync_p0_q, sync_p0_d;
    logic [SMP_W-1:0] sync_p1_q, sync_p1_d;
    logic [SMP_W-1:0] s;

    // Stability filter
    filt_state_t      filt_q, filt_d;
    logic [SMP_W-1:0] cand_q, cand_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             accept;

    // Decode of the accepted candidate
    logic [3:0]       glyph_nib;
    logic             glyph_hit;
    an_sel_t          an_sel;

    // Per-digit capture registers
    logic [3:0]       digit_q [4];
    logic [3:0]       digit_d [4];
    logic [3:0]       err_q, err_d;
    logic [3:0]       seen_q, seen_d;
    logic             ovr_q, ovr_d;

    // Output frame
    out_state_t       out_state_q, out_state_d;
    logic [15:0]      out_value_q, out_value_d;
    logic [3:0]       out_err_q, out_err_d;
    logic             out_overrun_q, out_overrun_d;
    logic             out_valid_q, out_valid_d;

    // ---- stage p0/p1: two-flop synchronizer, s = {anode, segments} ----
    always_comb begin
        sync_p0_d = {anode_in, segments_in};
        sync_p1_d = sync_p0_q;
    end

    assign s = sync_p1_q;

    // ---- stability filter: one accept per settled pattern ----
    always_comb begin
        filt_d = filt_q;
        cand_d = cand_q;
        cnt_d  = cnt_q;
        accept = 1'b0;
        if (s != cand_q) begin
            // Any change restarts settling, from either state.
            cand_d = s;
            cnt_d  = 8'd0;
            filt_d = FILT_SETTLING;
        end else if (filt_q == FILT_SETTLING) begin
            if (cnt_q == CNT_LAST) begin
                accept = 1'b1;
                filt_d = FILT_LOCKED;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    // On accept s == cand, so the registered candidate is decoded.
    seg7_glyph_decode u_glyph_decode (
        .pattern (cand_q[SEG_W-1:0]),
        .nibble  (glyph_nib),
        .hit     (glyph_hit)
    );

    assign an_sel = an_decode(cand_q[SMP_W-1:SEG_W]);

    // ---- capture and frame output ----
    always_comb begin
        digit_d       = digit_q;
        err_d         = err_q;
        seen_d        = seen_q;
        ovr_d         = ovr_q;
        out_state_d   = out_state_q;
        out_value_d   = out_value_q;
        out_err_d     = out_err_q;
        out_overrun_d = out_overrun_q;
        out_valid_d   = out_valid_q;

        case (out_state_q)
            OUT_EMPTY: begin
                if (seen_q == 4'hF) begin
                    out_value_d   = {digit_q[3], digit_q[2], digit_q[1], digit_q[0]};
                    out_err_d     = err_q;
                    out_overrun_d = ovr_q;
                    out_valid_d   = 1'b1;
                    seen_d        = 4'h0;
                    err_d         = 4'h0;
                    ovr_d         = 1'b0;
                    out_state_d   = OUT_FULL;
                end
            end
            OUT_FULL: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    out_state_d = OUT_EMPTY;
                end
            end
            default: begin
                out_state_d = OUT_EMPTY;
            end
        endcase

        // Applied on top of any frame-load clear, so a digit accepted in the
        // load cycle counts towards the next frame.
        if (accept && an_sel.valid) begin
            if (glyph_hit) begin
                digit_d[an_sel.idx] = glyph_nib;
                err_d[an_sel.idx]   = 1'b0;
            end else begin
                err_d[an_sel.idx]   = 1'b1;
            end
            if (seen_d[an_sel.idx]) begin
                ovr_d = 1'b1;
            end
            seen_d[an_sel.idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0_q     <= '1;
            sync_p1_q     <= '1;
            filt_q        <= FILT_SETTLING;
            cand_q        <= '1;
            cnt_q         <= 8'd0;
            digit_q       <= '{default: 4'h0};
            err_q         <= 4'h0;
            seen_q        <= 4'h0;
            ovr_q         <= 1'b0;
            out_state_q   <= OUT_EMPTY;
            out_value_q   <= 16'h0000;
            out_err_q     <= 4'h0;
            out_overrun_q <= 1'b0;
            out_valid_q   <= 1'b0;
        end else begin
            sync_p0_q     <= sync_p0_d;
            sync_p1_q     <= sync_p1_d;
            filt_q        <= filt_d;
            cand_q        <= cand_d;
            cnt_q         <= cnt_d;
            digit_q       <= digit_d;
            err_q         <= err_d;
            seen_q        <= seen_d;
            ovr_q         <= ovr_d;
            out_state_q   <= out_state_d;
            out_value_q   <= out_value_d;
            out_err_q     <= out_err_d;
            out_overrun_q <= out_overrun_d;
            out_valid_q   <= out_valid_d;
        end
    end

    assign out_value   = out_value_q;
    assign out_err     = out_err_q;
    assign out_overrun = out_overrun_q;
    assign out_valid   = out_valid_q;

endmodule

// File: doc/seg7_capture_decoder.md
# seg7_capture_decoder

Receive-side counterpart of the seven-segment display driver: samples the multiplexed active-low segment and anode lines of a 4-digit display, filters out multiplexing transitions, decodes each stable digit pattern back to a 4-bit hex nibble, and assembles complete 16-bit frames. Used in self-check and loopback builds on the Basys3 to verify what the display path actually drives. Frames are presented on a valid/ready handshake.

## Interface
- STABLE_CYCLES, 4: consecutive identical synchronized samples required before a pattern is accepted. Legal range is 2..255.
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- segments_in  in  [0:6]  segment lines a..g, index 0 = a, active-low
- anode_in  in  [3:0]  digit enables, active-low; 4'b0111 = digit 3 (leftmost), 1011 = 2, 1101 = 1, 1110 = 0
- out_value  out  16  {digit3, digit2, digit1, digit0}, nibble per digit
- out_err  out  4  per digit: the last accepted pattern for that digit was not a legal hex glyph
- out_overrun  out  1  at least one digit was re-captured after being seen, before the frame was delivered
- out_valid  out  1  frame available
- out_ready  in  1  consumer accepts frame

## Operation
- Both inputs pass through a 2-flop synchronizer. The synchronized value is s = {anode, segments}, 11 bits.
- The stability filter is a two-state FSM, SETTLING and LOCKED, with a candidate register cand and a counter cnt (8 bits).
  - If s != cand: cand <= s, cnt <= 0, go to SETTLING.
  - In SETTLING with s == cand: if cnt == STABLE_CYCLES-1, assert accept for one cycle and go to LOCKED. Otherwise cnt++.
  - In LOCKED with s == cand: hold. There is no further accept until the value changes.
- On accept, the anode pattern is checked first.
  - If the anode pattern is not exactly one zero (blanked 1111, or multiple enables): the sample is ignored.
  - Otherwise, with idx as the digit selected:
    - Legal glyph: digit[idx] <= nibble, err[idx] <= 0.
    - Illegal glyph: err[idx] <= 1 and digit[idx] is unchanged.
    - In both cases: if seen[idx] was already 1, ovr <= 1. Then seen[idx] <= 1.
- Glyph table, segments a..g, active-low, for values 0..F:
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110
  - 4 = 1001100, 5 = 0100100, 6 = 0100000, 7 = 0001111
  - 8 = 0000000, 9 = 0000100, A = 0001000, b = 1100000
  - C = 0110001, d = 1000010, E = 0110000, F = 0111000
  - Any other pattern is illegal.
- The output side is a two-state machine, EMPTY and FULL.
  - In EMPTY with seen == 1111: load out_value, out_err and out_overrun from digit, err and ovr; set out_valid = 1; clear seen, err and ovr; go to FULL.
  - In FULL: out_value, out_err and out_overrun are frozen. Capture continues into the digit, err, seen and ovr registers. When out_valid && out_ready, go to EMPTY and drop out_valid.
- Simultaneous accept and frame load: the clear is applied first, then the accept's update. The accepted digit therefore belongs to the new frame, with seen for that digit = 1.
- Reset values:
  - Outputs: out_valid = 0, out_value = 0, out_err = 0, out_overrun = 0.
  - Internal: seen = 0, err = 0, ovr = 0, all digit registers = 0, cand = all ones, cnt = 0, filter state SETTLING, output state EMPTY.
- Reset mid-capture or mid-handshake discards all partial and pending data. There is no frame output until four new digits are accepted.

## Timing
- Pins change and are first sampled at edge k. The new value appears in s after edge k+2, and cand is loaded at edge k+3.
- accept is asserted during the cycle after edge k+2+STABLE_CYCLES. The digit register updates at edge k+3+STABLE_CYCLES.
- If seen completes on edge n, out_valid rises at edge n+1.
- The handshake completes on any edge where out_valid && out_ready. The earliest next frame load is the following edge.
- A glitch shorter than STABLE_CYCLES synchronized cycles never produces accept.

## Structure
- Shared package seg7_pkg holds:
  - SEG_GLYPH[16] constants, which must be shared with the display driver.
  - Anode one-hot-low constants AN_DIGIT0..AN_DIGIT3.
  - A 2-bit digit index type.
- Sub-module seg7_glyph_decode is combinational: 7-bit pattern in, nibble and hit out, built from SEG_GLYPH.
- The top level contains the synchronizer, the stability FSM, the per-digit registers and the output FSM.

## Test plan
- Drive digits 3..0 = 1, 2, 3, 4, each held 10 cycles, with out_ready = 1 → out_value = 16'h1234 on one out_valid pulse; out_err = 0, out_overrun = 0.
- Hold a segment pattern for STABLE_CYCLES-1 cycles between legal digits → no digit update; the final frame is unchanged.
- Drive digit 2 with pattern 1111111 and the other digits legal → out_err = 4'b0100; nibble 2 keeps its previous value.
- Hold out_ready = 0 after the first frame, then scan 4 new digits twice → out_value stays frozen. After ready, the next frame shows the latest digits with out_overrun = 1.
- Drive anode 1111 and 0011 → ignored; seen is unchanged.
- Assert rst after 3 digits → all outputs 0. The next frame requires 4 fresh digits.
